// File: rtl/axi4_host_port_guard_if.sv
// AXI4 bundle for one side of axi4_host_port_guard. "slave" faces the host,
// "master" faces the accelerator.
interface axi4_host_port_guard_if #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned ADDR_WIDTH = 16,
  parameter int unsigned ID_WIDTH   = 8,
  parameter int unsigned STRB_WIDTH = DATA_WIDTH / 8
);
  logic                  awvalid;
  logic                  awready;
  logic [ID_WIDTH-1:0]   awid;
  logic [ADDR_WIDTH-1:0] awaddr;
  logic [7:0]            awlen;
  logic [2:0]            awsize;
  logic [1:0]            awburst;
  logic                  awlock;
  logic [3:0]            awcache;
  logic [2:0]            awprot;
  logic [3:0]            awqos;

  logic                  wvalid;
  logic                  wready;
  logic [DATA_WIDTH-1:0] wdata;
  logic [STRB_WIDTH-1:0] wstrb;
  logic                  wlast;

  logic                  bvalid;
  logic                  bready;
  logic [ID_WIDTH-1:0]   bid;
  logic [1:0]            bresp;

  logic                  arvalid;
  logic                  arready;
  logic [ID_WIDTH-1:0]   arid;
  logic [ADDR_WIDTH-1:0] araddr;
  logic [7:0]            arlen;
  logic [2:0]            arsize;
  logic [1:0]            arburst;
  logic                  arlock;
  logic [3:0]            arcache;
  logic [2:0]            arprot;
  logic [3:0]            arqos;

  logic                  rvalid;
  logic                  rready;
  logic [ID_WIDTH-1:0]   rid;
  logic [DATA_WIDTH-1:0] rdata;
  logic [1:0]            rresp;
  logic                  rlast;

  modport master (
    output awvalid, awid, awaddr, awlen, awsize, awburst, awlock, awcache, awprot, awqos,
    input  awready,
    output wvalid, wdata, wstrb, wlast,
    input  wready,
    input  bvalid, bid, bresp,
    output bready,
    output arvalid, arid, araddr, arlen, arsize, arburst, arlock, arcache, arprot, arqos,
    input  arready,
    input  rvalid, rid, rdata, rresp, rlast,
    output rready
  );

  modport slave (
    input  awvalid, awid, awaddr, awlen, awsize, awburst, awlock, awcache, awprot,
    output awready,
    input  wvalid, wdata, wstrb, wlast,
    output wready,
    output bvalid, bid, bresp,
    input  bready,
    input  arvalid, arid, araddr, arlen, arsize, arburst, arlock, arcache, arprot,
    output arready,
    output rvalid, rid, rdata, rresp, rlast,
    input  rready
  );
endinterface

// File: rtl/axi4_host_port_guard.sv
// AXI4 host-port guard: outstanding limits, W-after-AW gating, WLAST checking.
// Optional watchdog enabled by defining AXI_GUARD_TIMEOUT_EN.
module axi4_host_port_guard #(
  parameter int unsigned DATA_WIDTH      = 32,
  parameter int unsigned ADDR_WIDTH      = 16,
  parameter int unsigned ID_WIDTH        = 8,
  parameter int unsigned STRB_WIDTH      = DATA_WIDTH / 8,
  parameter int unsigned MAX_OUTSTANDING = 4,
  parameter int unsigned TIMEOUT_CYCLES  = 1024,
  localparam int unsigned CNT_W = $clog2(MAX_OUTSTANDING + 1),
  localparam int unsigned PTR_W = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1
) (
  input  logic                        clk,
  input  logic                        rst,
  axi4_host_port_guard_if.slave       s,
  axi4_host_port_guard_if.master      m,
  input  logic                        err_clr,
  output logic [CNT_W-1:0]            wr_outstanding,
  output logic [CNT_W-1:0]            rd_outstanding,
  output logic                        err_wlast,
  output logic                        err_timeout,
  output logic [7:0]                  err_count
);

  logic             wr_full, rd_full, lenq_full, lenq_empty;
  logic             aw_hs, w_hs, b_hs, ar_hs, r_hs;
  logic             b_dec, r_dec, w_final;
  logic             ev_wlast, ev_b, ev_r, ev_tmo;
  logic [7:0]       lq_mem [MAX_OUTSTANDING];
  logic [PTR_W-1:0] lq_wr_ptr, lq_rd_ptr;
  logic [CNT_W-1:0] lq_cnt;
  logic [7:0]       beat;
  logic [7:0]       head_len;
  logic [2:0]       err_inc;
  logic [8:0]       err_sum;

  assign wr_full    = (wr_outstanding == CNT_W'(MAX_OUTSTANDING));
  assign rd_full    = (rd_outstanding == CNT_W'(MAX_OUTSTANDING));
  assign lenq_full  = (lq_cnt == CNT_W'(MAX_OUTSTANDING));
  assign lenq_empty = (lq_cnt == '0);

  // AW channel
  assign m.awvalid = s.awvalid & ~wr_full & ~lenq_full;
  assign s.awready = m.awready & ~wr_full & ~lenq_full;
  assign m.awid    = ID_WIDTH'(s.awid);
  assign m.awaddr  = ADDR_WIDTH'(s.awaddr);
  assign m.awlen   = s.awlen;
  assign m.awsize  = s.awsize;
  assign m.awburst = s.awburst;
  assign m.awlock  = s.awlock;
  assign m.awcache = s.awcache;
  assign m.awprot  = s.awprot;
  assign m.awqos   = '0;

  // W channel: held back until the length queue holds a burst
  assign m.wvalid = s.wvalid & ~lenq_empty;
  assign s.wready = m.wready & ~lenq_empty;
  assign m.wdata  = DATA_WIDTH'(s.wdata);
  assign m.wstrb  = STRB_WIDTH'(s.wstrb);
  assign m.wlast  = s.wlast;

  // B channel
  assign s.bvalid = m.bvalid;
  assign m.bready = s.bready;
  assign s.bid    = m.bid;
  assign s.bresp  = m.bresp;

  // AR channel
  assign m.arvalid = s.arvalid & ~rd_full;
  assign s.arready = m.arready & ~rd_full;
  assign m.arid    = s.arid;
  assign m.araddr  = s.araddr;
  assign m.arlen   = s.arlen;
  assign m.arsize  = s.arsize;
  assign m.arburst = s.arburst;
  assign m.arlock  = s.arlock;
  assign m.arcache = s.arcache;
  assign m.arprot  = s.arprot;
  assign m.arqos   = '0;

  // R channel
  assign s.rvalid = m.rvalid;
  assign m.rready = s.rready;
  assign s.rid    = m.rid;
  assign s.rdata  = m.rdata;
  assign s.rresp  = m.rresp;
  assign s.rlast  = m.rlast;

  assign aw_hs = s.awvalid & s.awready;
  assign w_hs  = s.wvalid & s.wready;
  assign b_hs  = m.bvalid & s.bready;
  assign ar_hs = s.arvalid & s.arready;
  assign r_hs  = m.rvalid & s.rready;

  assign b_dec = b_hs & (wr_outstanding != '0);
  assign r_dec = r_hs & m.rlast & (rd_outstanding != '0);

  assign head_len = lq_mem[lq_rd_ptr];
  assign w_final  = (beat == head_len);

  assign ev_wlast = w_hs & (s.wlast != w_final);
  assign ev_b     = b_hs & (wr_outstanding == '0);
  assign ev_r     = r_hs & (rd_outstanding == '0);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_outstanding <= '0;
      rd_outstanding <= '0;
    end else begin
      if (aw_hs && !b_dec)      wr_outstanding <= wr_outstanding + 1'b1;
      else if (!aw_hs && b_dec) wr_outstanding <= wr_outstanding - 1'b1;
      if (ar_hs && !r_dec)      rd_outstanding <= rd_outstanding + 1'b1;
      else if (!ar_hs && r_dec) rd_outstanding <= rd_outstanding - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (aw_hs) lq_mem[lq_wr_ptr] <= s.awlen;
  end

  // Beats are counted against AWLEN; WLAST is only checked, never trusted.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      lq_wr_ptr <= '0;
      lq_rd_ptr <= '0;
      lq_cnt    <= '0;
      beat      <= '0;
    end else begin
      if (aw_hs)
        lq_wr_ptr <= (lq_wr_ptr == PTR_W'(MAX_OUTSTANDING - 1)) ? '0 : lq_wr_ptr + 1'b1;
      if (w_hs && w_final)
        lq_rd_ptr <= (lq_rd_ptr == PTR_W'(MAX_OUTSTANDING - 1)) ? '0 : lq_rd_ptr + 1'b1;
      if (aw_hs && !(w_hs && w_final))      lq_cnt <= lq_cnt + 1'b1;
      else if (!aw_hs && (w_hs && w_final)) lq_cnt <= lq_cnt - 1'b1;
      if (w_hs) beat <= w_final ? '0 : beat + 1'b1;
    end
  end

`ifdef AXI_GUARD_TIMEOUT_EN
  logic [31:0] wd_cnt;
  logic        wd_clear;

  assign wd_clear = aw_hs | w_hs | b_hs | ar_hs | r_hs |
                    ((wr_outstanding == '0) & (rd_outstanding == '0));
  // Counter parks at the limit so the event fires only once per stall.
  assign ev_tmo   = ~wd_clear & (wd_cnt == 32'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wd_cnt      <= '0;
      err_timeout <= 1'b0;
    end else begin
      if (wd_clear)                            wd_cnt <= '0;
      else if (wd_cnt != 32'(TIMEOUT_CYCLES))  wd_cnt <= wd_cnt + 1'b1;
      if (err_clr)     err_timeout <= 1'b0;
      else if (ev_tmo) err_timeout <= 1'b1;
    end
  end
`else
  assign ev_tmo      = 1'b0;
  assign err_timeout = 1'b0;
`endif

  assign err_inc = 3'(ev_wlast) + 3'(ev_b) + 3'(ev_r) + 3'(ev_tmo);
  assign err_sum = {1'b0, err_count} + 9'(err_inc);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err_wlast <= 1'b0;
      err_count <= '0;
    end else if (err_clr) begin
      err_wlast <= 1'b0;
      err_count <= '0;
    end else begin
      if (ev_wlast) err_wlast <= 1'b1;
      err_count <= err_sum[8] ? 8'hFF : err_sum[7:0];
    end
  end

endmodule

// File: tb/tb_axi4_host_port_guard.sv
// Directed bench for axi4_host_port_guard with a pass-through scoreboard.
module tb_axi4_host_port_guard;
  localparam int unsigned CW = 3;

  logic          clk = 1'b0;
  logic          rst;
  logic          err_clr;
  logic [CW-1:0] wr_outstanding, rd_outstanding;
  logic          err_wlast, err_timeout;
  logic [7:0]    err_count;

  int checks = 0;
  int errors = 0;

  logic [63:0] aw_q[$], w_q[$], b_q[$], ar_q[$], r_q[$];

  always #5 clk = ~clk;

  axi4_host_port_guard_if #(.DATA_WIDTH(32), .ADDR_WIDTH(16), .ID_WIDTH(8)) host ();
  axi4_host_port_guard_if #(.DATA_WIDTH(32), .ADDR_WIDTH(16), .ID_WIDTH(8)) acc ();

  axi4_host_port_guard #(
    .DATA_WIDTH(32), .ADDR_WIDTH(16), .ID_WIDTH(8),
    .MAX_OUTSTANDING(4), .TIMEOUT_CYCLES(16)
  ) dut (
    .clk(clk), .rst(rst), .s(host), .m(acc), .err_clr(err_clr),
    .wr_outstanding(wr_outstanding), .rd_outstanding(rd_outstanding),
    .err_wlast(err_wlast), .err_timeout(err_timeout), .err_count(err_count)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic monitor();
    if (acc.awvalid && acc.awready) begin
      if (aw_q.size() == 0) chk("aw_unexpected", 64'd1, 64'd0);
      else chk("aw_fields", {32'b0, acc.awid, acc.awaddr, acc.awlen}, aw_q.pop_front());
      chk("awqos", 64'(acc.awqos), 64'd0);
    end
    if (acc.wvalid && acc.wready) begin
      if (w_q.size() == 0) chk("w_unexpected", 64'd1, 64'd0);
      else chk("w_fields", {27'b0, acc.wlast, acc.wstrb, acc.wdata}, w_q.pop_front());
    end
    if (host.bvalid && host.bready) begin
      if (b_q.size() == 0) chk("b_unexpected", 64'd1, 64'd0);
      else chk("b_fields", {54'b0, host.bid, host.bresp}, b_q.pop_front());
    end
    if (acc.arvalid && acc.arready) begin
      if (ar_q.size() == 0) chk("ar_unexpected", 64'd1, 64'd0);
      else chk("ar_fields", {32'b0, acc.arid, acc.araddr, acc.arlen}, ar_q.pop_front());
    end
    if (host.rvalid && host.rready) begin
      if (r_q.size() == 0) chk("r_unexpected", 64'd1, 64'd0);
      else chk("r_fields", {21'b0, host.rid, host.rdata, host.rresp, host.rlast}, r_q.pop_front());
    end
  endtask

  task automatic cyc();
    @(negedge clk);
    monitor();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_aw(input logic [7:0] id, input logic [15:0] addr, input logic [7:0] len);
    host.awvalid = 1'b1; host.awid = id; host.awaddr = addr; host.awlen = len;
    aw_q.push_back({32'b0, id, addr, len});
  endtask

  task automatic drive_w(input logic [31:0] data, input logic last);
    host.wvalid = 1'b1; host.wdata = data; host.wstrb = 4'hF; host.wlast = last;
    w_q.push_back({27'b0, last, 4'hF, data});
  endtask

  task automatic drive_b(input logic [7:0] id);
    acc.bvalid = 1'b1; acc.bid = id; acc.bresp = 2'b00;
    b_q.push_back({54'b0, id, 2'b00});
  endtask

  task automatic drive_ar(input logic [7:0] id, input logic [15:0] addr);
    host.arvalid = 1'b1; host.arid = id; host.araddr = addr; host.arlen = 8'd0;
    ar_q.push_back({32'b0, id, addr, 8'd0});
  endtask

  task automatic drive_r(input logic [7:0] id, input logic [31:0] data);
    acc.rvalid = 1'b1; acc.rid = id; acc.rdata = data; acc.rresp = 2'b00; acc.rlast = 1'b1;
    r_q.push_back({21'b0, id, data, 2'b00, 1'b1});
  endtask

  initial begin
    rst = 1'b1; err_clr = 1'b0;
    host.awvalid = 0; host.awid = '0; host.awaddr = '0; host.awlen = '0;
    host.awsize = 3'd2; host.awburst = 2'd1; host.awlock = 0; host.awcache = '0; host.awprot = '0;
    host.awqos = '0; host.arqos = '0;
    host.wvalid = 0; host.wdata = '0; host.wstrb = '0; host.wlast = 0;
    host.bready = 1;
    host.arvalid = 0; host.arid = '0; host.araddr = '0; host.arlen = '0;
    host.arsize = 3'd2; host.arburst = 2'd1; host.arlock = 0; host.arcache = '0; host.arprot = '0;
    host.rready = 1;
    acc.awready = 1; acc.wready = 1; acc.arready = 1;
    acc.bvalid = 0; acc.bid = '0; acc.bresp = '0;
    acc.rvalid = 0; acc.rid = '0; acc.rdata = '0; acc.rresp = '0; acc.rlast = 0;

    repeat (2) @(posedge clk);
    #1;
    chk("rst_wr_out", 64'(wr_outstanding), 64'd0);
    chk("rst_rd_out", 64'(rd_outstanding), 64'd0);
    chk("rst_err_wlast", 64'(err_wlast), 64'd0);
    chk("rst_err_timeout", 64'(err_timeout), 64'd0);
    chk("rst_err_count", 64'(err_count), 64'd0);
    chk("rst_awready", 64'(host.awready), 64'd1);
    chk("rst_arready", 64'(host.arready), 64'd1);
    chk("rst_wready", 64'(host.wready), 64'd0);
    rst = 1'b0;
    cyc();

    // W before AW: held until the cycle after the AW handshake
    drive_w(32'hA000_0000, 1'b0);
    cyc();
    chk("pre_aw_wready", 64'(host.wready), 64'd0);
    chk("pre_aw_m_wvalid", 64'(acc.wvalid), 64'd0);
    drive_aw(8'd5, 16'h1234, 8'd3);
    chk("aw_cycle_no_bypass", 64'(host.wready), 64'd0);
    cyc();
    host.awvalid = 0;
    chk("post_aw_wready", 64'(host.wready), 64'd1);
    chk("post_aw_m_wvalid", 64'(acc.wvalid), 64'd1);
    chk("wr_out_one", 64'(wr_outstanding), 64'd1);
    cyc();
    for (int b = 1; b < 4; b++) begin
      drive_w(32'hA000_0000 + 32'(b), b == 3);
      cyc();
    end
    host.wvalid = 0;
    chk("burst4_err_wlast", 64'(err_wlast), 64'd0);
    chk("burst4_err_count", 64'(err_count), 64'd0);
    chk("burst4_wr_out", 64'(wr_outstanding), 64'd1);
    chk("burst4_q_empty", 64'(host.wready), 64'd0);
    drive_b(8'd5);
    cyc();
    acc.bvalid = 0;
    chk("after_b_wr_out", 64'(wr_outstanding), 64'd0);

    // Misplaced WLAST on a two-beat burst
    drive_aw(8'd6, 16'h2000, 8'd1);
    cyc();
    host.awvalid = 0;
    drive_w(32'hB000_0000, 1'b1);
    cyc();
    chk("early_last_err_wlast", 64'(err_wlast), 64'd1);
    chk("early_last_err_count", 64'(err_count), 64'd1);
    drive_w(32'hB000_0001, 1'b0);
    cyc();
    host.wvalid = 0;
    chk("missing_last_err_count", 64'(err_count), 64'd2);
    chk("missing_last_q_popped", 64'(host.wready), 64'd0);
    drive_b(8'd6);
    cyc();
    acc.bvalid = 0;
    err_clr = 1;
    cyc();
    err_clr = 0;
    chk("clr_err_wlast", 64'(err_wlast), 64'd0);
    chk("clr_err_count", 64'(err_count), 64'd0);

    // Read outstanding limit
    host.rready = 0;
    for (int i = 0; i < 4; i++) begin
      drive_ar(8'(i), 16'h0100 + 16'(i));
      cyc();
    end
    chk("rd_out_full", 64'(rd_outstanding), 64'd4);
    drive_ar(8'd4, 16'h0104);
    chk("ar5_held_arready", 64'(host.arready), 64'd0);
    chk("ar5_held_m_arvalid", 64'(acc.arvalid), 64'd0);
    cyc();
    cyc();
    chk("ar5_still_held", 64'(host.arready), 64'd0);
    host.rready = 1;
    drive_r(8'd0, 32'hC000_0000);
    cyc();
    acc.rvalid = 0;
    chk("ar5_released", 64'(host.arready), 64'd1);
    cyc();
    host.arvalid = 0;
    chk("rd_out_refilled", 64'(rd_outstanding), 64'd4);
    for (int i = 1; i < 5; i++) begin
      drive_r(8'(i), 32'hC000_0000 + 32'(i));
      cyc();
    end
    acc.rvalid = 0;
    chk("rd_out_drained", 64'(rd_outstanding), 64'd0);

    // Simultaneous AW + B, spurious B, clear winning over an error
    drive_aw(8'd1, 16'h0300, 8'd0);
    cyc();
    drive_aw(8'd2, 16'h0304, 8'd0);
    cyc();
    host.awvalid = 0;
    chk("wr_out_two", 64'(wr_outstanding), 64'd2);
    drive_aw(8'd3, 16'h0308, 8'd0);
    drive_b(8'd1);
    cyc();
    host.awvalid = 0;
    acc.bvalid = 0;
    chk("aw_b_same_cycle", 64'(wr_outstanding), 64'd2);
    for (int i = 0; i < 3; i++) begin
      drive_w(32'hD000_0000 + 32'(i), 1'b1);
      cyc();
    end
    host.wvalid = 0;
    chk("single_beats_no_err", 64'(err_count), 64'd0);
    drive_b(8'd2);
    cyc();
    drive_b(8'd3);
    cyc();
    acc.bvalid = 0;
    chk("wr_out_zero", 64'(wr_outstanding), 64'd0);
    drive_b(8'd9);
    cyc();
    acc.bvalid = 0;
    chk("spurious_b_err_count", 64'(err_count), 64'd1);
    chk("spurious_b_wr_out", 64'(wr_outstanding), 64'd0);
    drive_b(8'd10);
    err_clr = 1;
    cyc();
    acc.bvalid = 0;
    err_clr = 0;
    chk("clr_wins_err_count", 64'(err_count), 64'd0);

    // Stalled read, then reset mid-stall
    host.rready = 0;
    drive_ar(8'd7, 16'h0400);
    cyc();
    host.arvalid = 0;
    repeat (20) cyc();
    chk("stall_rd_out", 64'(rd_outstanding), 64'd1);
`ifdef AXI_GUARD_TIMEOUT_EN
    chk("timeout_flag", 64'(err_timeout), 64'd1);
    chk("timeout_err_count", 64'(err_count), 64'd1);
`else
    chk("no_watchdog_flag", 64'(err_timeout), 64'd0);
    chk("no_watchdog_count", 64'(err_count), 64'd0);
`endif
    rst = 1;
    #2;
    chk("mid_rst_rd_out", 64'(rd_outstanding), 64'd0);
    chk("mid_rst_wr_out", 64'(wr_outstanding), 64'd0);
    chk("mid_rst_err_timeout", 64'(err_timeout), 64'd0);
    chk("mid_rst_err_count", 64'(err_count), 64'd0);
    chk("mid_rst_err_wlast", 64'(err_wlast), 64'd0);
    chk("mid_rst_arready", 64'(host.arready), 64'd1);
    chk("mid_rst_wready", 64'(host.wready), 64'd0);
    @(posedge clk);
    #1;
    rst = 0;
    cyc();
    chk("scoreboard_drained",
        64'(aw_q.size() + w_q.size() + b_q.size() + ar_q.size() + r_q.size()), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
